// File: rtl/instruction_sequencer.sv
// Program store and instruction issuer for the 8-bit processor; optional Done timeout via SEQ_TIMEOUT_EN.
// One issue cycle per instruction, next issue right after Done; waits on Done indefinitely unless the timeout is built in.
module instruction_sequencer #(
  parameter int          ADDR_W  = 4,
  parameter logic [2:0]  HALT_OP = 3'b111,
  parameter int          TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [7:0]        LoadData,
  input  logic              Done,
  output logic [7:0]        DIN,
  output logic              Run,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Err,
  output logic [7:0]        InstrCount
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [2:0] OP_MVI = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_HALT
`ifdef SEQ_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic              pc_last;
  logic              idle_like;
  logic              load_ok;
  logic              pc_max;
  logic [ADDR_W-1:0] pc_inc;
  logic              go_issue;
  logic [ADDR_W-1:0] issue_addr;
  logic [7:0]        issue_word;
  logic              issue_halt;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  assign idle_like = (state == S_IDLE) || (state == S_HALT) || (state == S_ERR);
`else
  assign idle_like = (state == S_IDLE) || (state == S_HALT);
  // No timeout hardware in this build; the expression is constant low.
  assign Err = (TIMEOUT < 0);
`endif

  assign load_ok = LoadEn && idle_like;
  assign pc_max  = &PC;
  assign pc_inc  = PC + ADDR_W'(1);

  always_ff @(posedge Clk) begin
    if (load_ok)
      mem[LoadAddr] <= LoadData;
  end

  // Outputs are registered, so the word for the next ISSUE is looked up one cycle
  // early; a same-cycle load is forwarded and a halt opcode goes straight to HALT.
  always_comb begin
    go_issue   = 1'b0;
    issue_addr = PC;
    case (state)
      S_ISSUE: ;
      S_IMM:   if (Done && !pc_max) begin
                 go_issue   = 1'b1;
                 issue_addr = pc_inc;
               end
      S_WAIT:  if (Done && !pc_last) go_issue = 1'b1;
      default: if (idle_like && Start) begin
                 go_issue   = 1'b1;
                 issue_addr = '0;
               end
    endcase
    issue_word = (load_ok && (LoadAddr == issue_addr)) ? LoadData : mem[issue_addr];
    issue_halt = (issue_word[6:4] == HALT_OP);
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state      <= S_IDLE;
      DIN        <= '0;
      Run        <= 1'b0;
      PC         <= '0;
      Busy       <= 1'b0;
      Halted     <= 1'b0;
      InstrCount <= '0;
      pc_last    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      Err        <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_ISSUE: begin
          Run     <= 1'b0;
          pc_last <= pc_max;
          if (!pc_max) PC <= pc_inc;
`ifdef SEQ_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          if (DIN[6:4] == OP_MVI) begin
            state <= S_IMM;
            DIN   <= mem[pc_inc];
          end else begin
            state <= S_WAIT;
            DIN   <= '0;
          end
        end
        S_IMM, S_WAIT: begin
          if (Done) begin
            if (InstrCount != 8'hFF) InstrCount <= InstrCount + 8'd1;
            // End of memory reached: stop here unless go_issue takes over below.
            state  <= S_HALT;
            Halted <= 1'b1;
            Busy   <= 1'b0;
            DIN    <= '0;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state <= S_ERR;
            Err   <= 1'b1;
            Busy  <= 1'b0;
            DIN   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        default: begin
          if (Start) begin
            InstrCount <= '0;
`ifdef SEQ_TIMEOUT_EN
            Err        <= 1'b0;
`endif
          end
        end
      endcase

      if (go_issue) begin
        PC     <= issue_addr;
        Run    <= !issue_halt;
        Busy   <= !issue_halt;
        Halted <= issue_halt;
        DIN    <= issue_halt ? 8'h00 : issue_word;
        state  <= issue_halt ? S_HALT : S_ISSUE;
      end
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized bench for instruction_sequencer with a processor stand-in and a program-level reference model.
module tb_instruction_sequencer;

  localparam int AW = 4;
  localparam int N  = 16;

  logic          Clk = 1'b0;
  logic          Resetn = 1'b1;
  logic          Start = 1'b0;
  logic          LoadEn = 1'b0;
  logic [AW-1:0] LoadAddr = '0;
  logic [7:0]    LoadData = '0;
  logic          Done = 1'b0;
  logic [7:0]    DIN;
  logic          Run;
  logic [AW-1:0] PC;
  logic          Busy;
  logic          Halted;
  logic          Err;
  logic [7:0]    InstrCount;

  instruction_sequencer #(.ADDR_W(AW), .HALT_OP(3'b111), .TIMEOUT(15)) dut (
    .Clk(Clk), .Resetn(Resetn), .Start(Start), .LoadEn(LoadEn),
    .LoadAddr(LoadAddr), .LoadData(LoadData), .Done(Done),
    .DIN(DIN), .Run(Run), .PC(PC), .Busy(Busy), .Halted(Halted),
    .Err(Err), .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int op_delay(input logic [7:0] w);
    case (w[6:4])
      3'd0, 3'd1: return 1;
      3'd2, 3'd3: return 3;
      default:    return 2;
    endcase
  endfunction

  // Processor stand-in: latches the word on Run, raises Done op_delay cycles later.
  logic [7:0] ir;
  logic [7:0] R [4];
  int         rem = 0;
  bit         stall = 0;

  always @(negedge Clk) begin
    if (!Resetn) begin
      rem  = 0;
      Done = 1'b0;
    end else begin
      Done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          Done = 1'b1;
          case (ir[6:4])
            3'd0: R[ir[3:2]] = R[ir[1:0]];
            3'd1: R[ir[3:2]] = DIN;
            3'd2: R[ir[3:2]] = R[ir[3:2]] + R[ir[1:0]];
            3'd3: R[ir[3:2]] = R[ir[3:2]] - R[ir[1:0]];
            default: ;
          endcase
        end
      end
      if (Run && !stall) begin
        ir  = DIN;
        rem = op_delay(DIN);
      end
    end
  end

  // Reference model: walk the program image and list what must be issued and when.
  logic [7:0]    ref_mem [N];
  int            exp_cyc [$];
  logic [AW-1:0] exp_addr [$];
  logic [7:0]    exp_word [$];
  logic [7:0]    exp_imm [$];
  int            exp_halt_cyc;
  int            exp_pc;
  int            exp_cnt;

  task automatic compute_model();
    int pc, cyc, cnt;
    logic [7:0] w;
    exp_cyc.delete(); exp_addr.delete(); exp_word.delete(); exp_imm.delete();
    pc = 0; cyc = 1; cnt = 0;
    exp_halt_cyc = -1; exp_pc = 0;
    for (int it = 0; it <= N; it++) begin
      w = ref_mem[pc];
      if (w[6:4] == 3'b111) begin
        exp_halt_cyc = cyc; exp_pc = pc;
        break;
      end
      exp_cyc.push_back(cyc);
      exp_addr.push_back(AW'(pc));
      exp_word.push_back(w);
      cnt++;
      cyc += 1 + op_delay(w);
      if (w[6:4] == 3'b001) begin
        exp_imm.push_back(ref_mem[(pc + 1) % N]);
        if (pc >= N - 2) begin
          exp_halt_cyc = cyc; exp_pc = N - 1;
          break;
        end
        pc += 2;
      end else begin
        if (pc == N - 1) begin
          exp_halt_cyc = cyc; exp_pc = N - 1;
          break;
        end
        pc += 1;
      end
    end
    exp_cnt = (cnt > 255) ? 255 : cnt;
  endtask

  int            obs_cyc [$];
  logic [AW-1:0] obs_addr [$];
  logic [7:0]    obs_word [$];
  logic [7:0]    obs_imm [$];
  int            obs_halt_cyc;
  logic [AW-1:0] obs_pc;
  logic [7:0]    obs_cnt;
  logic          obs_err;
  int            busy_bad;
  bit            intf_hit;

  task automatic load_word(input int addr, input logic [7:0] data);
    LoadEn = 1'b1; LoadAddr = AW'(addr); LoadData = data;
    ref_mem[addr] = data;
    @(negedge Clk);
    LoadEn = 1'b0;
  endtask

  // Called at a negedge with the DUT idle or halted; that cycle is cycle 0.
  task automatic run_prog(input int budget, input bit ld0, input logic [7:0] ld0dat, input int intf_cyc);
    bit pend, got_halt;
    pend = 0; got_halt = 0; busy_bad = 0; intf_hit = 0;
    obs_cyc.delete(); obs_addr.delete(); obs_word.delete(); obs_imm.delete();
    obs_halt_cyc = -1;
    Start = 1'b1;
    if (ld0) begin
      LoadEn = 1'b1; LoadAddr = '0; LoadData = ld0dat;
    end
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge Clk);
      Start = 1'b0; LoadEn = 1'b0;
      if (Halted) begin
        obs_halt_cyc = cyc; obs_pc = PC; obs_cnt = InstrCount; obs_err = Err;
        got_halt = 1;
        break;
      end
      if (!Busy) busy_bad++;
      if (Run) begin
        obs_cyc.push_back(cyc); obs_addr.push_back(PC); obs_word.push_back(DIN);
        pend = (DIN[6:4] == 3'b001);
      end else if (pend) begin
        obs_imm.push_back(DIN);
        pend = 0;
      end
      if (cyc == intf_cyc && Busy) begin
        Start = 1'b1; LoadEn = 1'b1; LoadAddr = AW'(1); LoadData = 8'h70;
        intf_hit = 1;
      end
    end
    if (!got_halt) check("halt_reached", 0, 1);
  endtask

  task automatic compare(input string tag);
    check({tag, ":halt_cyc"}, obs_halt_cyc, exp_halt_cyc);
    check({tag, ":pc"}, 32'(obs_pc), exp_pc);
    check({tag, ":count"}, 32'(obs_cnt), exp_cnt);
    check({tag, ":err"}, 32'(obs_err), 0);
    check({tag, ":busy_gap"}, busy_bad, 0);
    check({tag, ":n_run"}, obs_cyc.size(), exp_cyc.size());
    check({tag, ":n_imm"}, obs_imm.size(), exp_imm.size());
    for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
      check($sformatf("%s:run%0d_cyc", tag, i), obs_cyc[i], exp_cyc[i]);
      check($sformatf("%s:run%0d_pc", tag, i), 32'(obs_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s:run%0d_din", tag, i), 32'(obs_word[i]), 32'(exp_word[i]));
    end
    for (int i = 0; i < exp_imm.size() && i < obs_imm.size(); i++)
      check($sformatf("%s:imm%0d", tag, i), 32'(obs_imm[i]), 32'(exp_imm[i]));
  endtask

  task automatic run_and_compare(input string tag, input bit ld0, input logic [7:0] ld0dat, input int intf_cyc);
    if (ld0) ref_mem[0] = ld0dat;
    compute_model();
    run_prog(120, ld0, ld0dat, intf_cyc);
    compare(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":DIN"}, 32'(DIN), 0);
    check({tag, ":Run"}, 32'(Run), 0);
    check({tag, ":PC"}, 32'(PC), 0);
    check({tag, ":Busy"}, 32'(Busy), 0);
    check({tag, ":Halted"}, 32'(Halted), 0);
    check({tag, ":Err"}, 32'(Err), 0);
    check({tag, ":InstrCount"}, 32'(InstrCount), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    int first_err;
    for (int i = 0; i < 4; i++) R[i] = 8'h00;

    #1 Resetn = 1'b0;
    repeat (2) @(negedge Clk);
    check_all_zero("reset");
    Resetn = 1'b1;
    @(negedge Clk);

    // Reference program with processor registers observed.
    load_word(0, 8'h10); load_word(1, 8'h05); load_word(2, 8'h14);
    load_word(3, 8'h04); load_word(4, 8'h21); load_word(5, 8'h70);
    run_and_compare("prog1", 0, 8'h00, 0);
    check("prog1:run_at_1", obs_cyc[0], 1);
    check("prog1:run_at_3", obs_cyc[1], 3);
    check("prog1:run_at_5", obs_cyc[2], 5);
    check("prog1:first_imm", 32'(obs_imm[0]), 32'h05);
    check("prog1:halt_at_9", obs_halt_cyc, 9);
    check("prog1:R0", 32'(R[0]), 32'h09);
    check("prog1:R1", 32'(R[1]), 32'h04);

    // mv everywhere: runs off the end of memory.
    for (int a = 0; a < N; a++) load_word(a, 8'h01);
    run_and_compare("all_mv", 0, 8'h00, 0);
    check("all_mv:pc15", 32'(obs_pc), 15);
    check("all_mv:count16", 32'(obs_cnt), 16);

    // Halt opcode at address 0.
    load_word(0, 8'h70);
    run_and_compare("halt0", 0, 8'h00, 0);
    check("halt0:halt_at_1", obs_halt_cyc, 1);
    check("halt0:no_run", obs_cyc.size(), 0);

    // Start and LoadEn while busy must change nothing.
    load_word(0, 8'h01); load_word(1, 8'h21); load_word(2, 8'h31);
    load_word(3, 8'h10); load_word(4, 8'h99); load_word(5, 8'h82);
    load_word(6, 8'h70);
    run_and_compare("busy_intf", 0, 8'h00, 2);
    check("busy_intf:hit", 32'(intf_hit), 1);
    run_and_compare("busy_rerun", 0, 8'h00, 0);

    // Reset during an add WAIT.
    load_word(0, 8'h21); load_word(1, 8'h01); load_word(2, 8'h37);
    load_word(3, 8'h70);
    Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    check("rst_mid:issue_run", 32'(Run), 1);
    @(negedge Clk);
    check("rst_mid:wait_busy", 32'(Busy), 1);
    Resetn = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge Clk); Resetn = 1'b1;
    @(negedge Clk);
    run_and_compare("rst_rerun", 0, 8'h00, 0);

    // Done withheld after the first Run.
    stall = 1;
    Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    first_err = -1;
    for (int c = 1; c <= 40; c++) begin
      if (Err && first_err < 0) first_err = c;
      @(negedge Clk);
    end
    check("stall:err_cycle", first_err, 15 + 2);
    check("stall:err_busy", 32'(Busy), 0);
    stall = 0;
    run_and_compare("stall_restart", 0, 8'h00, 0);
`else
    first_err = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!Busy || Err) first_err++;
      @(negedge Clk);
    end
    check("stall:busy_held", first_err, 0);
    stall = 0;
    Resetn = 1'b0;
    @(negedge Clk); Resetn = 1'b1;
    @(negedge Clk);
    run_and_compare("stall_recover", 0, 8'h00, 0);
`endif

    // Random programs, some starting with a same-cycle load of address 0.
    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < N; a++) begin
        w = 8'($urandom_range(0, 255));
        if (w[6:4] == 3'b111 && $urandom_range(0, 3) != 0) w[6:4] = 3'($urandom_range(0, 6));
        load_word(a, w);
      end
      w = 8'($urandom_range(0, 255));
      w[6:4] = 3'($urandom_range(0, 3));
      run_and_compare($sformatf("rand%0d", it), it[0], w, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
